// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e        : 2-bit controller state encoding
//   TimeoutDefault : default memory-wait limit before the fatal error state
//   CntWDefault    : default performance-counter width
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLuStall = 2'd1,
      StMemWait = 2'd2,
      StError   = 2'd3
   } state_e;

   localparam int unsigned TimeoutDefault = 255;
   localparam int unsigned CntWDefault    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
//   clk_i   : clock
//   clear_i : synchronous clear, dominates inc_i
//   inc_i   : increment enable; the count sticks at all-ones
//   count_o : current count
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory
// wait handling with a fatal timeout, and two saturating performance counters.
//   clk, reset (sync, active-low)
//   IDEXMemRead/IDEXRt, IFIDRs/IFIDRt : load-use detection inputs
//   BranchTaken                       : branch resolved taken in ID
//   DMemReq/DMemReady                 : data-memory handshake
//   PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, EXMEMHold : pipeline controls
//   MemTimeout                        : sticky fatal timeout flag
//   StallCycles, FlushCount           : saturating performance counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault,
   parameter int unsigned CNT_W   = CntWDefault
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IDEXMemRead,
   input  logic [4:0]       IDEXRt,
   input  logic [4:0]       IFIDRs,
   input  logic [4:0]       IFIDRt,
   input  logic             BranchTaken,
   input  logic             DMemReq,
   input  logic             DMemReady,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXBubble,
   output logic             IFIDFlush,
   output logic             EXMEMHold,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);

   // Wide enough to hold TIMEOUT itself.
   localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WaitW:0] TimeoutVal = (WaitW + 1)'(TIMEOUT);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [WaitW:0]   wait_nxt;
   logic             mem_stall;
   logic             load_use;

   assign mem_stall = DMemReq && !DMemReady;
   assign load_use  = IDEXMemRead && (IDEXRt != 5'd0) &&
                      ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));

   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXBubble = 1'b0;
      IFIDFlush  = 1'b0;
      EXMEMHold  = 1'b0;
      MemTimeout = 1'b0;
      state_d    = state_q;
      wait_d     = wait_q;
      // Entering MEM_WAIT counts as the first wait cycle.
      wait_nxt   = (state_q == StMemWait) ? ({1'b0, wait_q} + (WaitW + 1)'(1))
                                          : (WaitW + 1)'(1);

      if (state_q == StError) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         EXMEMHold  = 1'b1;
         MemTimeout = 1'b1;
      end else if (mem_stall) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         EXMEMHold = 1'b1;
         wait_d    = wait_nxt[WaitW-1:0];
         state_d   = (wait_nxt >= TimeoutVal) ? StError : StMemWait;
      end else begin
         wait_d = '0;
         // LU_STALL ignores load_use so the interlock lasts exactly one cycle.
         if ((state_q == StRun) && load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            state_d    = StLuStall;
         end else begin
            state_d   = StRun;
            IFIDFlush = BranchTaken;
         end
      end

      if (!reset) begin
         PCWrite    = 1'b1;
         IFIDWrite  = 1'b1;
         IDEXBubble = 1'b0;
         IFIDFlush  = 1'b0;
         EXMEMHold  = 1'b0;
         MemTimeout = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StRun;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   sat_counter #(
      .Width (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk),
      .clear_i (!reset),
      .inc_i   (!PCWrite),
      .count_o (StallCycles)
   );

   sat_counter #(
      .Width (CNT_W)
   ) u_flush_cnt (
      .clk_i   (clk),
      .clear_i (!reset),
      .inc_i   (IFIDFlush),
      .count_o (FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          IDEXMemRead;
   logic [4:0]    IDEXRt, IFIDRs, IFIDRt;
   logic          BranchTaken, DMemReq, DMemReady;
   logic          PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, EXMEMHold, MemTimeout;
   logic [CW-1:0] StallCycles, FlushCount;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .IDEXMemRead (IDEXMemRead),
      .IDEXRt      (IDEXRt),
      .IFIDRs      (IFIDRs),
      .IFIDRt      (IFIDRt),
      .BranchTaken (BranchTaken),
      .DMemReq     (DMemReq),
      .DMemReady   (DMemReady),
      .PCWrite     (PCWrite),
      .IFIDWrite   (IFIDWrite),
      .IDEXBubble  (IDEXBubble),
      .IFIDFlush   (IFIDFlush),
      .EXMEMHold   (EXMEMHold),
      .MemTimeout  (MemTimeout),
      .StallCycles (StallCycles),
      .FlushCount  (FlushCount)
   );

   always #5 clk = ~clk;

   // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, EXMEMHold, MemTimeout}
   logic [5:0] outs;
   assign outs = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, EXMEMHold, MemTimeout};

   localparam logic [5:0] Idle  = 6'b110000;
   localparam logic [5:0] LuSet = 6'b001000;
   localparam logic [5:0] Flush = 6'b110100;
   localparam logic [5:0] Hold  = 6'b000010;
   localparam logic [5:0] Err   = 6'b000011;

   typedef struct {
      string      name;
      logic       mr;
      logic [4:0] ex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       br;
      logic       req;
      logic       rdy;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req,
                         input logic rdy);
      IDEXMemRead = mr;
      IDEXRt      = ex_rt;
      IFIDRs      = rs;
      IFIDRt      = rt;
      BranchTaken = br;
      DMemReq     = req;
      DMemReady   = rdy;
      #1;
   endtask

   task automatic do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("outs_in_reset", int'(outs), int'(Idle));
      tick();
      reset = 1'b1;
      #1;
      chk("reset_stall_cnt", int'(StallCycles), 0);
      chk("reset_flush_cnt", int'(FlushCount), 0);
      chk("reset_outs", int'(outs), int'(Idle));

      // Single-cycle decode checks, each from a fresh RUN state.
      vecs[0]  = '{"idle",         1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, Idle};
      vecs[1]  = '{"lu_rs",        1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, LuSet};
      vecs[2]  = '{"lu_rt",        1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, LuSet};
      vecs[3]  = '{"r0_exempt",    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, Idle};
      vecs[4]  = '{"no_memread",   1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, Idle};
      vecs[5]  = '{"no_match",     1'b1, 5'd7, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, Idle};
      vecs[6]  = '{"branch",       1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, Flush};
      vecs[7]  = '{"mem_stall",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, Hold};
      vecs[8]  = '{"mem_ready",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, Idle};
      vecs[9]  = '{"mem_over_all", 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, Hold};
      vecs[10] = '{"lu_over_br",   1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, LuSet};
      vecs[11] = '{"rdy_no_req",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, Flush};

      for (int i = 0; i < 12; i++) begin
         do_reset();
         set_in(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].br,
                vecs[i].req, vecs[i].rdy);
         chk(vecs[i].name, int'(outs), int'(vecs[i].exp));
      end

      // Load-use interlock lasts exactly one cycle.
      do_reset();
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("lu_cycle1", int'(outs), int'(LuSet));
      tick();
      chk("lu_stall_cnt1", int'(StallCycles), 1);
      chk("lu_stall_ignored", int'(outs), int'(Idle));
      tick();
      chk("lu_stall_cnt_hold", int'(StallCycles), 1);
      chk("lu_back_in_run", int'(outs), int'(LuSet));

      // Memory wait of three cycles, then ready.
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("memwait_hold%0d", i), int'(outs), int'(Hold));
         tick();
      end
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      chk("memwait_release", int'(outs), int'(Idle));
      tick();
      chk("memwait_stall_cnt", int'(StallCycles), 3);
      set_in(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
      chk("memwait_then_run", int'(outs), int'(LuSet));

      // Timeout to ERROR, sticky until reset, stall counter saturates.
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("timeout_not_yet", int'(MemTimeout), 0);
      tick();
      chk("timeout_err_outs", int'(outs), int'(Err));
      chk("timeout_stall_cnt", int'(StallCycles), 4);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      tick();
      chk("timeout_sticky", int'(outs), int'(Err));
      chk("timeout_no_flush", int'(FlushCount), 0);
      for (int i = 0; i < 15; i++) tick();
      chk("stall_saturate", int'(StallCycles), 15);
      reset = 1'b0;
      #1;
      chk("err_reset_outs", int'(outs), int'(Idle));
      tick();
      reset = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("err_reset_tmo", int'(MemTimeout), 0);
      chk("err_reset_stall", int'(StallCycles), 0);

      // Branch masked by load-use is dropped; next-cycle branch flushes.
      do_reset();
      set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
      chk("br_masked_flush", int'(IFIDFlush), 0);
      tick();
      chk("br_masked_cnt", int'(FlushCount), 0);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      chk("br_alone_flush", int'(outs), int'(Flush));
      tick();
      chk("br_alone_cnt", int'(FlushCount), 1);
      for (int i = 0; i < 18; i++) tick();
      chk("flush_saturate", int'(FlushCount), 15);

      // Reset on the second wait cycle.
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("midwait_reset_outs", int'(outs), int'(Idle));
      tick();
      reset = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("midwait_stall_cnt", int'(StallCycles), 0);
      chk("midwait_flush_cnt", int'(FlushCount), 0);
      chk("midwait_idle", int'(outs), int'(Idle));
      set_in(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("midwait_in_run", int'(outs), int'(LuSet));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum consecutive memory-wait cycles before a fatal error.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
REQ-005 IDEXMemRead  in  1  instruction in ID/EX is a load.
REQ-006 IDEXRt  in  5  load destination register in ID/EX.
REQ-007 IFIDRs  in  5  source register Rs of the instruction in IF/ID.
REQ-008 IFIDRt  in  5  source register Rt of the instruction in IF/ID.
REQ-009 BranchTaken  in  1  branch resolved taken in ID.
REQ-010 DMemReq  in  1  EX/MEM stage has an active data-memory access.
REQ-011 DMemReady  in  1  data memory completes the access this cycle.
REQ-012 PCWrite  out  1  PC update enable.
REQ-013 IFIDWrite  out  1  IF/ID register write enable.
REQ-014 IDEXBubble  out  1  zero the control fields of ID/EX.
REQ-015 IFIDFlush  out  1  replace IF/ID with a NOP.
REQ-016 EXMEMHold  out  1  freeze EX/MEM and the whole back end.
REQ-017 MemTimeout  out  1  sticky fatal memory-timeout flag.
REQ-018 StallCycles  out  CNT_W  saturating count of cycles with PCWrite=0.
REQ-019 FlushCount  out  CNT_W  saturating count of IFIDFlush pulses.

Function
REQ-020 FSM states SHALL be RUN, LU_STALL, MEM_WAIT and ERROR.
REQ-021 Term mem_stall SHALL be DMemReq && !DMemReady.
REQ-022 Term load_use SHALL be IDEXMemRead && IDEXRt!=0 && (IDEXRt==IFIDRs || IDEXRt==IFIDRt).
REQ-023 Outputs SHALL be combinational from state and inputs; priority is ERROR > mem_stall > load_use > BranchTaken.
REQ-024 ERROR output set: PCWrite=0, IFIDWrite=0, EXMEMHold=1, MemTimeout=1; all other outputs 0.
REQ-025 mem_stall output set (any non-ERROR state): PCWrite=0, IFIDWrite=0, EXMEMHold=1, IDEXBubble=0, IFIDFlush=0.
REQ-026 load_use in RUN output set: PCWrite=0, IFIDWrite=0, IDEXBubble=1; next state is LU_STALL.
REQ-027 LU_STALL SHALL last exactly one cycle; load_use is ignored there; next state is RUN unless mem_stall.
REQ-028 BranchTaken, when no higher-priority condition holds: IFIDFlush=1, PCWrite=1; state unchanged.
REQ-029 BranchTaken masked by a stall SHALL be ignored; no flush, no FlushCount increment.
REQ-030 Idle output set: PCWrite=1, IFIDWrite=1, all others 0.
REQ-031 RUN or LU_STALL with mem_stall SHALL enter MEM_WAIT and load the wait counter with 1.
REQ-032 MEM_WAIT: each mem_stall cycle increments the wait counter; when !mem_stall, next state is RUN and the counter clears.
REQ-033 Wait counter reaching TIMEOUT while mem_stall holds SHALL move to ERROR; ERROR is left only by reset.
REQ-034 StallCycles SHALL increment on every cycle with PCWrite=0 and saturate at all-ones.
REQ-035 FlushCount SHALL increment on every IFIDFlush=1 cycle and saturate at all-ones.

Reset
REQ-036 reset=0 at a rising edge SHALL force state RUN, wait counter 0, MemTimeout 0, StallCycles 0, FlushCount 0, regardless of the current state, including mid-MEM_WAIT and ERROR.
REQ-037 While reset=0, outputs SHALL show the idle set (PCWrite=1, IFIDWrite=1, others 0).

Structure
REQ-038 A shared package SHALL hold the state encoding (2-bit: RUN=0, LU_STALL=1, MEM_WAIT=2, ERROR=3) and the TIMEOUT default.
REQ-039 The two performance counters SHALL be instances of one sub-module, sat_counter (parameter width, inc and clear inputs).

Verification
REQ-040 Load-use: IDEXMemRead=1, IDEXRt=5, IFIDRs=5 -> one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1, then RUN; StallCycles=1.
REQ-041 R0 exemption: IDEXMemRead=1, IDEXRt=0, IFIDRt=0 -> no stall; PCWrite=1.
REQ-042 Memory wait: DMemReq=1, DMemReady=0 for 3 cycles then 1 -> EXMEMHold=1 for 3 cycles, then RUN; StallCycles=3.
REQ-043 Timeout: TIMEOUT=4, DMemReady held 0 -> ERROR after the 4th wait cycle, MemTimeout=1 persists until reset=0.
REQ-044 Priority: BranchTaken=1 together with load_use -> IFIDFlush=0, FlushCount unchanged; BranchTaken alone next cycle -> IFIDFlush=1, FlushCount=1.
REQ-045 Reset mid-MEM_WAIT: reset=0 on wait cycle 2 -> RUN, counters 0, idle output set.
